// File: rtl/fixed_sqrt_pipe.sv
// Signed fixed-point square root, digit-by-digit restoring, one root bit per cycle; rounding build option FIXED_SQRT_ROUND_EN.
// Latency N+1 cycles (negative operand: 1); accepts only in IDLE, result held until ready_in.
module fixed_sqrt_pipe #(
    parameter  int WIDTH     = 32,
    parameter  int FRAC_BITS = 11,
    localparam int N         = (WIDTH - 1 + FRAC_BITS + 1) / 2,
    localparam int RW        = N + 1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] input_val,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] result,
    output logic [RW-1:0]    remainder,
    output logic             error_out
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, ERR, DONE} state_t;

    state_t             state_q;
    logic [2*N-1:0]     rad_q;
    logic [N+1:0]       rem_q;
    logic [N-1:0]       root_q;
    logic [CW-1:0]      cnt_q;
    logic               last_q;
    logic               valid_q;
    logic               error_q;
    logic [WIDTH-1:0]   result_q;
    logic [RW-1:0]      remainder_q;

    logic [2*N-1:0]     rad_init;
    logic [N+1:0]       rem_shift;
    logic [N+1:0]       trial;
    logic               take;
    logic [N+1:0]       rem_d;
    logic [N-1:0]       root_d;
    logic [N:0]         root_rnd;

    // Radicand R = operand << F; sign bit is known zero on this path.
    always_comb begin
        rad_init = '0;
        rad_init[WIDTH-2:0] = input_val[WIDTH-2:0];
        rad_init = rad_init << FRAC_BITS;
    end

    // Top two bits of rem_q are always zero here since rem <= 2*root before the shift.
    assign rem_shift = {rem_q[N-1:0], rad_q[2*N-1 -: 2]};
    assign trial     = {root_q, 2'b01};
    assign take      = (rem_shift >= trial);
    assign rem_d     = take ? (rem_shift - trial) : rem_shift;
    assign root_d    = (root_q << 1) | N'(take);

`ifdef FIXED_SQRT_ROUND_EN
    assign root_rnd = (rem_q > {2'b00, root_q}) ? ({1'b0, root_q} + (N+1)'(1)) : {1'b0, root_q};
`else
    assign root_rnd = {1'b0, root_q};
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            rad_q       <= '0;
            rem_q       <= '0;
            root_q      <= '0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            result_q    <= '0;
            remainder_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_in) begin
                        if (input_val[WIDTH-1]) begin
                            state_q <= ERR;
                        end else begin
                            state_q <= CALC;
                            rad_q   <= rad_init;
                            rem_q   <= '0;
                            root_q  <= '0;
                            cnt_q   <= CW'(N - 1);
                            last_q  <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    if (!last_q) begin
                        rem_q  <= rem_d;
                        root_q <= root_d;
                        rad_q  <= rad_q << 2;
                        if (cnt_q == '0) begin
                            last_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end else begin
                        // All N digits resolved: publish, folding in the optional round-up.
                        state_q     <= DONE;
                        valid_q     <= 1'b1;
                        error_q     <= 1'b0;
                        result_q    <= WIDTH'(root_rnd);
                        remainder_q <= rem_q[RW-1:0];
                    end
                end
                ERR: begin
                    state_q     <= DONE;
                    valid_q     <= 1'b1;
                    error_q     <= 1'b1;
                    result_q    <= '0;
                    remainder_q <= '0;
                end
                DONE: begin
                    if (ready_in) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready_out = (state_q == IDLE);
    assign valid_out = valid_q;
    assign error_out = error_q;
    assign result    = result_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_fixed_sqrt_pipe.sv
// Randomised and directed bench for fixed_sqrt_pipe against an arithmetic square-root model.
module tb_fixed_sqrt_pipe;

    localparam int W  = 32;
    localparam int F  = 11;
    localparam int N  = (W - 1 + F + 1) / 2;
    localparam int RW = N + 1;

    typedef struct packed {
        logic [W-1:0]  res;
        logic [RW-1:0] rm;
        logic          er;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_in = 1'b0;
    logic          ready_in = 1'b1;
    logic [W-1:0]  input_val = '0;
    logic          ready_out;
    logic          valid_out;
    logic [W-1:0]  result;
    logic [RW-1:0] remainder;
    logic          error_out;

    int checks = 0;
    int failures = 0;

    fixed_sqrt_pipe #(.WIDTH(W), .FRAC_BITS(F)) dut (
        .clk_in    (clk),
        .rst_n_in  (rst_n),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .input_val (input_val),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .result    (result),
        .remainder (remainder),
        .error_out (error_out)
    );

    always #5 clk = ~clk;

    // floor(sqrt(x * 2^F)) by greedy bit search on squares
    function automatic exp_t model(input logic [W-1:0] x);
        exp_t e;
        longint unsigned r, root, b, rem;
        e = '0;
        if (x[W-1]) begin
            e.er = 1'b1;
            return e;
        end
        r = 64'(x) << F;
        root = 0;
        for (int i = N - 1; i >= 0; i--) begin
            b = root | (64'd1 << i);
            if (b * b <= r) root = b;
        end
        rem = r - root * root;
        e.rm = RW'(rem);
`ifdef FIXED_SQRT_ROUND_EN
        if (rem > root) root = root + 1;
`endif
        e.res = W'(root);
        return e;
    endfunction

    // Issue one operand from a negedge; returns at the negedge where valid_out is first seen.
    task automatic run_op(input logic [W-1:0] x, output exp_t got, output int lat);
        int guard;
        guard = 0;
        while (!ready_out && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!ready_out) begin
            checks++; failures++;
            $display("FAIL accept_timeout: ready_out=%0b required 1", ready_out);
        end
        valid_in  = 1'b1;
        input_val = x;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        lat = 0;
        while (!valid_out && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        got.res = result;
        got.rm  = remainder;
        got.er  = error_out;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
        #12;
        checks++;
        if ({valid_out, error_out, result, remainder} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%0b err=%0b res=%h rem=%h required all 0",
                     valid_out, error_out, result, remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: ready=%0b valid=%0b required 1/0", ready_out, valid_out);
        end
    endtask

    task automatic test_directed;
        logic [W-1:0]  ops  [4];
        logic [W-1:0]  eres [4];
        logic [RW-1:0] erem [4];
        exp_t got;
        int lat;
        ops[0] = 32'h0000_2000; eres[0] = 32'h0000_1000; erem[0] = '0;
        ops[1] = 32'h0000_0007; erem[1] = RW'(175);
        ops[2] = 32'h7FFF_FFFF; erem[2] = RW'(4192255);
        ops[3] = 32'h0000_0000; eres[3] = '0; erem[3] = '0;
`ifdef FIXED_SQRT_ROUND_EN
        eres[1] = 32'd120;
        eres[2] = 32'h0020_0000;
`else
        eres[1] = 32'd119;
        eres[2] = 32'd2097151;
`endif
        ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], got, lat);
            checks++;
            if (got.res !== eres[i] || got.rm !== erem[i] || got.er !== 1'b0) begin
                failures++;
                $display("FAIL directed_%0d: res=%h rem=%0d err=%0b required res=%h rem=%0d err=0",
                         i, got.res, got.rm, got.er, eres[i], erem[i]);
            end
            checks++;
            if (lat !== N + 1) begin
                failures++;
                $display("FAIL directed_latency_%0d: %0d cycles required %0d", i, lat, N + 1);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_negative;
        exp_t got;
        int lat;
        ready_in = 1'b0;
        run_op(32'hFFFF_FFFF, got, lat);
        checks++;
        if (got.er !== 1'b1 || got.res !== '0 || got.rm !== '0) begin
            failures++;
            $display("FAIL negative_outputs: err=%0b res=%h rem=%h required 1/0/0", got.er, got.res, got.rm);
        end
        checks++;
        if (lat !== 1) begin
            failures++;
            $display("FAIL negative_latency: %0d cycles required 1", lat);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ready_out !== 1'b0 || valid_out !== 1'b1) begin
                failures++;
                $display("FAIL negative_hold: ready=%0b valid=%0b required 0/1", ready_out, valid_out);
            end
        end
        ready_in = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
            failures++;
            $display("FAIL negative_release: ready=%0b valid=%0b required 1/0", ready_out, valid_out);
        end
    endtask

    task automatic test_backpressure;
        exp_t got, e;
        int lat, seen;
        e = model(32'h0000_0007);
        ready_in = 1'b0;
        run_op(32'h0000_0007, got, lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            valid_in  = (i == 4);
            input_val = 32'h0000_2000;
            checks++;
            if (valid_out !== 1'b1 || ready_out !== 1'b0 || result !== e.res ||
                remainder !== e.rm || error_out !== e.er) begin
                failures++;
                $display("FAIL backpressure_hold_%0d: valid=%0b ready=%0b res=%h rem=%0d required 1/0 res=%h rem=%0d",
                         i, valid_out, ready_out, result, remainder, e.res, e.rm);
            end
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_idle: ready=%0b valid=%0b required 1/0", ready_out, valid_out);
        end
        seen = 0;
        for (int i = 0; i < N + 5; i++) begin
            @(negedge clk);
            if (valid_out || !ready_out) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL backpressure_ignored_pulse: %0d busy cycles required 0", seen);
        end
    endtask

    task automatic test_random;
        exp_t got, e;
        logic [W-1:0] x;
        int lat;
        ready_in = 1'b1;
        for (int i = 0; i < 30; i++) begin
            case (i % 3)
                0: x = $urandom & 32'h7FFF_FFFF;
                1: x = 32'($urandom_range(0, 5000));
                default: x = $urandom;
            endcase
            e = model(x);
            run_op(x, got, lat);
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL random_%0d x=%h: res=%h rem=%0d err=%0b required res=%h rem=%0d err=%0b",
                         i, x, got.res, got.rm, got.er, e.res, e.rm, e.er);
            end
            checks++;
            if (lat !== (x[W-1] ? 1 : N + 1)) begin
                failures++;
                $display("FAIL random_latency_%0d: %0d cycles required %0d", i, lat, x[W-1] ? 1 : N + 1);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] ops [8];
        exp_t q [$];
        exp_t e;
        int idx, got_n, cyc;
        logic acc;
        for (int i = 0; i < 8; i++) ops[i] = (i == 3) ? 32'h8000_0000 : ($urandom & 32'h7FFF_FFFF);
        ready_in = 1'b1;
        @(negedge clk);
        idx = 0; got_n = 0; cyc = 0;
        valid_in = 1'b1;
        input_val = ops[0];
        while (got_n < 8 && cyc < 1000) begin
            if (valid_out) begin
                e = (q.size() > 0) ? q.pop_front() : '0;
                checks++;
                if ({result, remainder, error_out} !== e) begin
                    failures++;
                    $display("FAIL back_to_back_%0d: res=%h rem=%0d err=%0b required res=%h rem=%0d err=%0b",
                             got_n, result, remainder, error_out, e.res, e.rm, e.er);
                end
                got_n++;
            end
            acc = valid_in && ready_out;
            if (acc) q.push_back(model(ops[idx]));
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 8) input_val = ops[idx];
                else valid_in = 1'b0;
            end
        end
        valid_in = 1'b0;
        checks++;
        if (got_n !== 8) begin
            failures++;
            $display("FAIL back_to_back_timeout: %0d results required 8", got_n);
        end
    endtask

    task automatic test_reset_mid_calc;
        exp_t got, e;
        int lat, seen;
        ready_in = 1'b1;
        run_op(32'h7FFF_FFFF, got, lat);
        @(negedge clk);
        valid_in = 1'b1;
        input_val = 32'h0000_2000;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({valid_out, error_out, result, remainder} !== '0 || ready_out !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_calc: valid=%0b err=%0b res=%h rem=%h ready=%0b required 0/0/0/0/1",
                     valid_out, error_out, result, remainder, ready_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < N + 8; i++) begin
            @(negedge clk);
            if (valid_out) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL reset_lost_result: valid_out seen %0d cycles required 0", seen);
        end
        e = model(32'h0000_2000);
        run_op(32'h0000_2000, got, lat);
        checks++;
        if (got !== e || got.res !== 32'h0000_1000 || lat !== N + 1) begin
            failures++;
            $display("FAIL reset_recovery: res=%h rem=%0d lat=%0d required res=00001000 rem=0 lat=%0d",
                     got.res, got.rm, lat, N + 1);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_negative();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_reset_mid_calc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
